// File: rtl/apb_cmd_master.sv
// APB3 master driven by a valid/ready command stream; one response per command.
// A transfer stuck on PREADY low is aborted after TIMEOUT ACCESS cycles (0 = never).
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
  // cmd_ready depends only on state; rsp_valid, once raised, holds with a stable payload
  // until rsp_ready is seen high.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                pwrite_q;
  logic                psel_q;
  logic                penable_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic                timeout_hit;

  // True on the ACCESS cycle whose PREADY-low would bring the count to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            pwrite_q <= cmd_write;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a timeout expiring in the same cycle.
          if (PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWDATA      = pwdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized command/slave stimulus for apb_cmd_master, scored against a
// transaction-level model of response contents and ACCESS-phase length.
module tb_apb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW+1:0] exp_q[$];

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a slave inserting 'waits' wait states completes on ACCESS
  // cycle waits+1 unless the TO-cycle limit is reached first.
  function automatic int model_access(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  function automatic logic [DW+1:0] model_rsp(input logic wr, input int waits,
                                               input logic slverr, input logic [DW-1:0] rdata);
    if (waits >= TO) return {1'b1, 1'b1, {DW{1'b0}}};
    return {1'b0, slverr, wr ? {DW{1'b0}} : rdata};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel"},    PSEL, 0);
    check({tag, "_penable"}, PENABLE, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // Driver: called just after a negedge with the DUT idle; returns just after
  // the negedge following the response handshake.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic slverr, input logic [DW-1:0] rdata,
                         input int rsp_delay);
    int acc;
    int lat;
    logic [DW+1:0] exp_w;
    logic [DW+1:0] held;
    exp_q.push_back(model_rsp(wr, waits, slverr, rdata));
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    @(posedge PCLK);
    @(negedge PCLK);
    // keep cmd_valid high with junk to show it is ignored mid-transfer
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom_range(0, 1));
    lat = 1;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    if (wr) check("setup_pwdata", PWDATA, wdata);
    PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1));
    acc = 0;
    for (int g = 0; g < 64; g++) begin
      @(negedge PCLK);
      lat++;
      if (!(PSEL && PENABLE)) break;
      acc++;
      check("access_paddr", PADDR, addr);
      check("access_pwrite", PWRITE, wr);
      if (acc > waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      end
    end
    // outside ACCESS the slave lines are noise
    PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    check("access_cycles", acc, model_access(waits));
    check("rsp_latency", lat, model_access(waits) + 2);
    check("rsp_valid", rsp_valid, 1);
    exp_w = exp_q.pop_front();
    check("rsp_payload", {rsp_timeout, rsp_err, rsp_rdata}, exp_w);
    held = {rsp_timeout, rsp_err, rsp_rdata};
    rsp_ready = 1'b0;
    for (int d = 0; d < rsp_delay; d++) begin
      @(negedge PCLK);
      PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_payload", {rsp_timeout, rsp_err, rsp_rdata}, held);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_psel", PSEL, 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check_idle_outputs("post_hs");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1));
      @(negedge PCLK);
      check("gap_psel", PSEL, 0);
    end
  endtask

  initial begin
    logic [AW-1:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    check_idle_outputs("reset");
    check("reset_paddr", PADDR, 0);
    check("reset_pwdata", PWDATA, 0);
    check("reset_pwrite", PWRITE, 0);
    check("reset_payload", {rsp_timeout, rsp_err, rsp_rdata}, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // directed cases
    run_cmd(1'b1, 32'h4, 32'h55, 0, 1'b0, '0, 0);               // zero-wait write
    run_cmd(1'b0, 32'h8, '0, 3, 1'b0, 32'h0000_00AA, 0);         // 3 wait states read
    run_cmd(1'b0, 32'h8, '0, 20, 1'b0, 32'h1234_5678, 1);        // timeout
    run_cmd(1'b1, 32'h0, 32'hDEAD_BEEF, 2, 1'b1, '0, 0);         // slave error
    run_cmd(1'b0, 32'h4, '0, TO - 1, 1'b1, 32'hCAFE_F00D, 0);    // PREADY on last allowed cycle
    run_cmd(1'b1, 32'h4, 32'h77, 1, 1'b0, '0, 5);                // response back-pressure
    run_cmd(1'b0, 32'h8, '0, 0, 1'b0, 32'h0BAD_0001, 0);         // back-to-back after handshake

    // reset during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hA5A5_5A5A; PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_paddr", PADDR, 0);
    check("mid_reset_pwdata", PWDATA, 0);
    check("mid_reset_pwrite", PWRITE, 0);
    check("mid_reset_payload", {rsp_timeout, rsp_err, rsp_rdata}, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    run_cmd(1'b0, 32'h4, '0, 1, 1'b0, 32'h0000_0042, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      run_cmd(wr, addrs[$urandom_range(0, 2)], $urandom, $urandom_range(0, TO + 2),
              1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
